// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, PC-source encodings and FSM state type for the pipeline
// sequencing controller.
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_JUMP = 4'hB;
    localparam logic [3:0] OP_JR   = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MUL = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational detection of load-use hazards and ID-stage redirects
// (JUMP / JR) for the pipeline sequencing controller.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic [3:0]        id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [3:0]        ex_op,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              lu_hz,
    output logic              jmp,
    output logic              jr
);

    // r0 is hardwired to zero, so a load targeting it can never create a hazard
    assign lu_hz = (ex_op == OP_LW) && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (ex_rd == id_rt));
    assign jmp   = (id_op == OP_JUMP);
    assign jr    = (id_op == OP_JR);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: pipeline-register enables, flushes and
// bubbles, PC source select, MUL occupancy FSM and a stall-cycle counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYC = 4,
    parameter int REG_AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [3:0]        ex_op,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_taken,
    output logic              pc_wen,
    output logic [1:0]        pc_sel,
    output logic              ifid_wen,
    output logic              ifid_flush,
    output logic              idex_wen,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic              busy,
    output logic [15:0]       stall_cnt
);

    // The RUN cycle that sees the MUL is the first of MUL_CYC-1 stall cycles
    localparam logic [3:0] CNT_INIT = 4'(MUL_CYC - 2);

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       lu_hz, jmp, jr;
    logic       id_rules;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .id_op (id_op),
        .id_rs (id_rs),
        .id_rt (id_rt),
        .ex_op (ex_op),
        .ex_rd (ex_rd),
        .lu_hz (lu_hz),
        .jmp   (jmp),
        .jr    (jr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_wen && stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Branch beats MUL beats the ID-stage rules; the release cycle of a MUL
    // falls through to the ID-stage rules so a held JUMP/JR redirects there
    always_comb begin
        next_state   = state;
        next_cnt     = cnt;
        pc_wen       = 1'b1;
        pc_sel       = PC_SEQ;
        ifid_wen     = 1'b1;
        ifid_flush   = 1'b0;
        idex_wen     = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        busy         = 1'b0;
        id_rules     = 1'b0;

        case (state)
            S_RUN: begin
                if (ex_taken) begin
                    pc_sel      = PC_BR;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (ex_op == OP_MUL) begin
                    pc_wen       = 1'b0;
                    ifid_wen     = 1'b0;
                    idex_wen     = 1'b0;
                    exmem_bubble = 1'b1;
                    busy         = 1'b1;
                    next_state   = S_MUL;
                    next_cnt     = CNT_INIT;
                end else begin
                    id_rules = 1'b1;
                end
            end
            S_MUL: begin
                if (cnt != 4'd0) begin
                    pc_wen       = 1'b0;
                    ifid_wen     = 1'b0;
                    idex_wen     = 1'b0;
                    exmem_bubble = 1'b1;
                    busy         = 1'b1;
                    next_cnt     = cnt - 4'd1;
                end else begin
                    next_state = S_RUN;
                    id_rules   = 1'b1;
                end
            end
            default: next_state = S_RUN;
        endcase

        // A load-use stall defers any redirect until the ID instruction reissues
        if (id_rules) begin
            if (lu_hz) begin
                pc_wen      = 1'b0;
                ifid_wen    = 1'b0;
                idex_bubble = 1'b1;
            end else if (jmp) begin
                pc_sel     = PC_JMP;
                ifid_flush = 1'b1;
            end else if (jr) begin
                pc_sel     = PC_JR;
                ifid_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_wen       = 1'b0;
            pc_sel       = PC_SEQ;
            ifid_wen     = 1'b0;
            ifid_flush   = 1'b1;
            idex_wen     = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            busy         = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with MUL_CYC=4; outputs are
// packed as {pc_wen, pc_sel, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_bubble, busy}.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_op, id_rs, id_rt, ex_op, ex_rd;
    logic        ex_taken;
    logic        pc_wen, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_bubble, busy;
    logic [1:0]  pc_sel;
    logic [15:0] stall_cnt;
    logic [8:0]  outs;

    int errors = 0;
    int checks = 0;

    localparam logic [8:0] O_DEF = 9'b1_00_1_0_1_0_0_0;
    localparam logic [8:0] O_LU  = 9'b0_00_0_0_1_1_0_0;
    localparam logic [8:0] O_MUL = 9'b0_00_0_0_0_0_1_1;
    localparam logic [8:0] O_BR  = 9'b1_01_1_1_1_1_0_0;
    localparam logic [8:0] O_JMP = 9'b1_10_1_1_1_0_0_0;
    localparam logic [8:0] O_JR  = 9'b1_11_1_1_1_0_0_0;
    localparam logic [8:0] O_RST = 9'b0_00_0_1_0_1_1_0;

    pipe_ctrl #(.MUL_CYC(4), .REG_AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_op        (id_op),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_op        (ex_op),
        .ex_rd        (ex_rd),
        .ex_taken     (ex_taken),
        .pc_wen       (pc_wen),
        .pc_sel       (pc_sel),
        .ifid_wen     (ifid_wen),
        .ifid_flush   (ifid_flush),
        .idex_wen     (idex_wen),
        .idex_bubble  (idex_bubble),
        .exmem_bubble (exmem_bubble),
        .busy         (busy),
        .stall_cnt    (stall_cnt)
    );

    assign outs = {pc_wen, pc_sel, ifid_wen, ifid_flush, idex_wen, idex_bubble, exmem_bubble, busy};

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 2ns later
    task automatic applyStimulus(input logic [3:0] iop, input logic [3:0] irs, input logic [3:0] irt,
                                 input logic [3:0] eop, input logic [3:0] erd, input logic tk);
        id_op = iop; id_rs = irs; id_rt = irt;
        ex_op = eop; ex_rd = erd; ex_taken = tk;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(OP_NOP, 4'd0, 4'd0, OP_NOP, 4'd0, 1'b0);
        checks++; if (outs !== O_RST) begin errors++; $display("[TB] FAIL reset_outs: got %b want %b", outs, O_RST); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(OP_NOP, 4'd0, 4'd0, OP_NOP, 4'd0, 1'b0);
        checks++; if (outs !== O_DEF) begin errors++; $display("[TB] FAIL post_reset_outs: got %b want %b", outs, O_DEF); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        applyStimulus(OP_ADD, 4'd3, 4'd1, OP_LW, 4'd3, 1'b0);
        checks++; if (outs !== O_LU) begin errors++; $display("[TB] FAIL lu_rs: got %b want %b", outs, O_LU); end
        @(negedge clk);
        applyStimulus(OP_ADD, 4'd3, 4'd1, OP_NOP, 4'd0, 1'b0);
        checks++; if (outs !== O_DEF) begin errors++; $display("[TB] FAIL lu_after: got %b want %b", outs, O_DEF); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL lu_cnt1: got %0d want 1", stall_cnt); end
        @(negedge clk);
        applyStimulus(OP_SUB, 4'd2, 4'd5, OP_LW, 4'd5, 1'b0);
        checks++; if (outs !== O_LU) begin errors++; $display("[TB] FAIL lu_rt: got %b want %b", outs, O_LU); end
        @(negedge clk);
        applyStimulus(OP_ADD, 4'd1, 4'd2, OP_LW, 4'd7, 1'b0);
        checks++; if (outs !== O_DEF) begin errors++; $display("[TB] FAIL lu_nomatch: got %b want %b", outs, O_DEF); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("[TB] FAIL lu_cnt2: got %0d want 2", stall_cnt); end
        @(negedge clk);
    endtask

    task automatic test_r0();
        applyStimulus(OP_ADD, 4'd0, 4'd0, OP_LW, 4'd0, 1'b0);
        checks++; if (outs !== O_DEF) begin errors++; $display("[TB] FAIL r0_nostall: got %b want %b", outs, O_DEF); end
        @(negedge clk);
        applyStimulus(OP_NOP, 4'd0, 4'd0, OP_NOP, 4'd0, 1'b0);
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("[TB] FAIL r0_cnt: got %0d want 2", stall_cnt); end
        @(negedge clk);
    endtask

    task automatic test_mul();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_ADD, 4'd1, 4'd2, OP_MUL, 4'd4, 1'b0);
            checks++; if (outs !== O_MUL) begin errors++; $display("[TB] FAIL mul_stall%0d: got %b want %b", i, outs, O_MUL); end
            @(negedge clk);
        end
        applyStimulus(OP_ADD, 4'd1, 4'd2, OP_MUL, 4'd4, 1'b0);
        checks++; if (outs !== O_DEF) begin errors++; $display("[TB] FAIL mul_release: got %b want %b", outs, O_DEF); end
        @(negedge clk);
        applyStimulus(OP_NOP, 4'd0, 4'd0, OP_NOP, 4'd0, 1'b0);
        checks++; if (outs !== O_DEF) begin errors++; $display("[TB] FAIL mul_run: got %b want %b", outs, O_DEF); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("[TB] FAIL mul_cnt: got %0d want 5", stall_cnt); end
        @(negedge clk);
    endtask

    task automatic test_branch();
        applyStimulus(OP_ADD, 4'd3, 4'd0, OP_LW, 4'd3, 1'b1);
        checks++; if (outs !== O_BR) begin errors++; $display("[TB] FAIL br_over_lu: got %b want %b", outs, O_BR); end
        @(negedge clk);
        applyStimulus(OP_JUMP, 4'd0, 4'd0, OP_BEQ, 4'd0, 1'b1);
        checks++; if (outs !== O_BR) begin errors++; $display("[TB] FAIL br_over_jmp: got %b want %b", outs, O_BR); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("[TB] FAIL br_cnt: got %0d want 5", stall_cnt); end
        @(negedge clk);
        applyStimulus(OP_NOP, 4'd0, 4'd0, OP_BEQ, 4'd0, 1'b0);
        checks++; if (outs !== O_DEF) begin errors++; $display("[TB] FAIL br_not_taken: got %b want %b", outs, O_DEF); end
        @(negedge clk);
    endtask

    task automatic test_jump();
        applyStimulus(OP_JUMP, 4'd0, 4'd0, OP_ADD, 4'd2, 1'b0);
        checks++; if (outs !== O_JMP) begin errors++; $display("[TB] FAIL jump: got %b want %b", outs, O_JMP); end
        @(negedge clk);
        applyStimulus(OP_JR, 4'd6, 4'd0, OP_ADD, 4'd2, 1'b0);
        checks++; if (outs !== O_JR) begin errors++; $display("[TB] FAIL jr: got %b want %b", outs, O_JR); end
        @(negedge clk);
        applyStimulus(OP_JR, 4'd6, 4'd0, OP_LW, 4'd6, 1'b0);
        checks++; if (outs !== O_LU) begin errors++; $display("[TB] FAIL jr_deferred: got %b want %b", outs, O_LU); end
        @(negedge clk);
        applyStimulus(OP_JR, 4'd6, 4'd0, OP_NOP, 4'd0, 1'b0);
        checks++; if (outs !== O_JR) begin errors++; $display("[TB] FAIL jr_reissue: got %b want %b", outs, O_JR); end
        checks++; if (stall_cnt !== 16'd6) begin errors++; $display("[TB] FAIL jr_cnt: got %0d want 6", stall_cnt); end
        @(negedge clk);
    endtask

    task automatic test_mul_jump();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_JUMP, 4'd0, 4'd0, OP_MUL, 4'd4, 1'b0);
            checks++; if (outs !== O_MUL) begin errors++; $display("[TB] FAIL mj_hold%0d: got %b want %b", i, outs, O_MUL); end
            @(negedge clk);
        end
        applyStimulus(OP_JUMP, 4'd0, 4'd0, OP_MUL, 4'd4, 1'b0);
        checks++; if (outs !== O_JMP) begin errors++; $display("[TB] FAIL mj_release: got %b want %b", outs, O_JMP); end
        @(negedge clk);
        applyStimulus(OP_NOP, 4'd0, 4'd0, OP_NOP, 4'd0, 1'b0);
        checks++; if (stall_cnt !== 16'd9) begin errors++; $display("[TB] FAIL mj_cnt: got %0d want 9", stall_cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_ADD, 4'd1, 4'd2, OP_MUL, 4'd4, 1'b0);
            checks++; if (outs !== O_MUL) begin errors++; $display("[TB] FAIL rm_pre%0d: got %b want %b", i, outs, O_MUL); end
            if (i < 2) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++; if (outs !== O_RST) begin errors++; $display("[TB] FAIL rm_outs: got %b want %b", outs, O_RST); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rm_cnt: got %0d want 0", stall_cnt); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OP_ADD, 4'd1, 4'd2, OP_MUL, 4'd4, 1'b0);
            checks++; if (outs !== O_MUL) begin errors++; $display("[TB] FAIL rm_fresh%0d: got %b want %b", i, outs, O_MUL); end
            @(negedge clk);
        end
        applyStimulus(OP_ADD, 4'd1, 4'd2, OP_MUL, 4'd4, 1'b0);
        checks++; if (outs !== O_DEF) begin errors++; $display("[TB] FAIL rm_release: got %b want %b", outs, O_DEF); end
        @(negedge clk);
        applyStimulus(OP_NOP, 4'd0, 4'd0, OP_NOP, 4'd0, 1'b0);
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL rm_final_cnt: got %0d want 3", stall_cnt); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        id_op = OP_NOP; id_rs = '0; id_rt = '0;
        ex_op = OP_NOP; ex_rd = '0; ex_taken = 1'b0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_r0();
        test_mul();
        test_branch();
        test_jump();
        test_mul_jump();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
